// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Round-robin issue controller sharing one multi-cycle ALU between
//            two requesters, with class-based latency and a tagged response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
    parameter int BASIC_LAT = 2,
    parameter int MUL_LAT   = 4,
    parameter int DIV_LAT   = 34
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_op1,
    input  logic [31:0] req0_op2,
    input  logic [4:0]  req0_opcode,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_op1,
    input  logic [31:0] req1_op2,
    input  logic [4:0]  req1_opcode,

    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [4:0]  alu_opcode,
    input  logic [31:0] alu_answer,

    output logic        resp_valid,
    output logic        resp_id,
    output logic [31:0] resp_data,
    input  logic        resp_ready,

    output logic        busy
);

    localparam int MAX_LAT_BM = (BASIC_LAT > MUL_LAT) ? BASIC_LAT : MUL_LAT;
    localparam int MAX_LAT    = (MAX_LAT_BM > DIV_LAT) ? MAX_LAT_BM : DIV_LAT;
    localparam int CNT_W      = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_grant_q;
    logic               busy_q;
    logic [31:0]        alu_op1_q;
    logic [31:0]        alu_op2_q;
    logic [4:0]         alu_opcode_q;
    logic               resp_valid_q;
    logic               resp_id_q;
    logic [31:0]        resp_data_q;

    logic               grant0;
    logic               grant1;
    logic               issue;
    logic [31:0]        sel_op1;
    logic [31:0]        sel_op2;
    logic [4:0]         sel_opcode;

    generate
        if (BASIC_LAT < 1 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_param_check
            $error("alu_issue_ctrl: all latencies must be 1 or more");
        end
    endgenerate

    function automatic logic [CNT_W-1:0] class_lat(input logic [4:0] opc);
        if (opc >= 5'd2 && opc <= 5'd5) begin
            return CNT_W'(MUL_LAT);
        end else if (opc >= 5'd6 && opc <= 5'd9) begin
            return CNT_W'(DIV_LAT);
        end else begin
            return CNT_W'(BASIC_LAT);
        end
    endfunction

    // On a tie the requester that did not win last time gets the ALU.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && state_q == S_IDLE) begin
            grant0 = req0_valid && (!req1_valid || last_grant_q);
            grant1 = req1_valid && (!req0_valid || !last_grant_q);
        end
    end

    assign issue      = grant0 | grant1;
    assign sel_op1    = grant1 ? req1_op1    : req0_op1;
    assign sel_op2    = grant1 ? req1_op2    : req0_op2;
    assign sel_opcode = grant1 ? req1_opcode : req0_opcode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            alu_opcode_q <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        alu_op1_q    <= sel_op1;
                        alu_op2_q    <= sel_op2;
                        alu_opcode_q <= sel_opcode;
                        resp_id_q    <= grant1;
                        last_grant_q <= grant1;
                        cnt_q        <= class_lat(sel_opcode);
                        busy_q       <= 1'b1;
                        state_q      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    cnt_q <= cnt_q - 1'b1;
                    // Final count: the ALU answer is valid on this edge.
                    if (cnt_q == CNT_W'(1)) begin
                        resp_data_q  <= alu_answer;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign alu_opcode = alu_opcode_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign busy       = busy_q;

`ifndef SYNTHESIS
    a_one_grant : assert property (@(posedge clk) disable iff (!rst_n)
        !(req0_ready && req1_ready));
    a_ready_idle : assert property (@(posedge clk) disable iff (!rst_n)
        (req0_ready || req1_ready) |-> (state_q == S_IDLE));
    a_busy_state : assert property (@(posedge clk) disable iff (!rst_n)
        busy_q == (state_q != S_IDLE));
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Scoreboard bench for alu_issue_ctrl with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

    localparam int BASIC_LAT = 2;
    localparam int MUL_LAT   = 4;
    localparam int DIV_LAT   = 34;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [4:0]  req0_opcode = '0, req1_opcode = '0;
    logic [31:0] alu_op1, alu_op2, alu_answer;
    logic [4:0]  alu_opcode;
    logic        resp_valid, resp_id, resp_ready = 1'b1, busy;
    logic [31:0] resp_data;

    alu_issue_ctrl #(
        .BASIC_LAT (BASIC_LAT),
        .MUL_LAT   (MUL_LAT),
        .DIV_LAT   (DIV_LAT)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_op1    (req0_op1),
        .req0_op2    (req0_op2),
        .req0_opcode (req0_opcode),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_op1    (req1_op1),
        .req1_op2    (req1_op2),
        .req1_opcode (req1_opcode),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_opcode  (alu_opcode),
        .alu_answer  (alu_answer),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_data   (resp_data),
        .resp_ready  (resp_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op);
        if (op >= 5'd2 && op <= 5'd5)      return a * b;
        else if (op >= 5'd6 && op <= 5'd9) return (b == 0) ? 32'hFFFF_FFFF : a / b;
        else if (op == 5'd0)               return a + b;
        else                               return a ^ b;
    endfunction

    function automatic int lat_of(input logic [4:0] op);
        if (op >= 5'd2 && op <= 5'd5)      return MUL_LAT;
        else if (op >= 5'd6 && op <= 5'd9) return DIV_LAT;
        else                               return BASIC_LAT;
    endfunction

    assign alu_answer = alu_ref(alu_op1, alu_op2, alu_opcode);

    typedef struct {
        logic        id;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  opc;
        logic [31:0] data;
        int          issue;
        int          lat;
    } exp_t;

    exp_t sb[$];
    bit   grant_log[$];
    int   cyc = 0;
    int   busy_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic rv_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: handshakes push the expected result, a rising resp_valid pops it.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (req0_valid && req0_ready) begin
                sb.push_back('{1'b0, req0_op1, req0_op2, req0_opcode,
                               alu_ref(req0_op1, req0_op2, req0_opcode), cyc + 1, lat_of(req0_opcode)});
                grant_log.push_back(1'b0);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back('{1'b1, req1_op1, req1_op2, req1_opcode,
                               alu_ref(req1_op1, req1_op2, req1_opcode), cyc + 1, lat_of(req1_opcode)});
                grant_log.push_back(1'b1);
            end
            if (busy && !resp_valid && sb.size() > 0) begin
                chk("alu_op1_hold", alu_op1, sb[0].op1);
                chk("alu_op2_hold", alu_op2, sb[0].op2);
                chk("alu_opc_hold", {27'd0, alu_opcode}, {27'd0, sb[0].opc});
            end
            if (resp_valid && !rv_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_id", {31'd0, resp_id}, {31'd0, e.id});
                    chk("resp_data", resp_data, e.data);
                    chk("resp_latency", cyc - e.issue, e.lat);
                end
            end
            if (busy) busy_cnt++;
        end
        rv_prev = rst_n ? resp_valid : 1'b0;
    end

    task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op, input bit ready_now);
        bit done = 1'b0;
        @(posedge clk); #2;
        if (id) begin
            req1_valid = 1'b1; req1_op1 = a; req1_op2 = b; req1_opcode = op;
        end else begin
            req0_valid = 1'b1; req0_op1 = a; req0_op2 = b; req0_opcode = op;
        end
        #1;
        if (ready_now) chk("issue_ready", {31'd0, id ? req1_ready : req0_ready}, 32'd1);
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) done = 1'b1;
        end
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
        @(posedge clk); #2;
        // Operands may wander once the requester is no longer being served.
        if (id) begin
            req1_valid = 1'b0; req1_op1 = $urandom; req1_op2 = $urandom;
        end else begin
            req0_valid = 1'b0; req0_op1 = $urandom; req0_op2 = $urandom;
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (!busy && !resp_valid && sb.size() == 0) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        bit          done;
        bit          exp_rr [4];
        exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state, with a request already pending.
        req0_valid = 1'b1;
        #3;
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_alu_op1", alu_op1, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single basic op.
        busy_cnt = 0;
        send(1'b0, 32'd5, 32'd7, 5'b00000, 1'b1);
        wait_idle();
        chk("t1_busy_cycles", busy_cnt, 32'd3);
        chk("t1_add_data", resp_data, 32'd12);

        // Multiply then divide latency from requester 1.
        send(1'b1, 32'd6, 32'd9, 5'b00010, 1'b1);
        wait_idle();
        send(1'b1, 32'd1000, 32'd7, 5'b00110, 1'b1);
        wait_idle();

        // Round-robin with both requesters continuously valid.
        grant_log.delete();
        @(posedge clk); #2;
        req0_valid = 1'b1; req0_op1 = 32'd10; req0_op2 = 32'd3; req0_opcode = 5'b00000;
        req1_valid = 1'b1; req1_op1 = 32'd50; req1_op2 = 32'd8; req1_opcode = 5'b00001;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(posedge clk);
            if (grant_log.size() >= 4) done = 1'b1;
        end
        #2 req0_valid = 1'b0; req1_valid = 1'b0;
        if (!done) chk("rr_timeout", 32'd0, 32'd1);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) chk("rr_grant", {31'd0, grant_log[i]}, {31'd0, exp_rr[i]});
            else chk("rr_grant_missing", 32'd0, 32'd1);
        end

        // Back-pressure: hold the response for 10 cycles.
        resp_ready = 1'b0;
        send(1'b0, 32'd3, 32'd11, 5'b00011, 1'b0);
        done = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (resp_valid) done = 1'b1;
        end
        if (!done) chk("bp_resp_timeout", 32'd0, 32'd1);
        held = resp_data;
        chk("bp_held_data", held, 32'd33);
        @(posedge clk); #2;
        req1_valid = 1'b1; req1_op1 = 32'd4; req1_op2 = 32'd4; req1_opcode = 5'b00000;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_resp_data", resp_data, held);
            chk("bp_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        end
        @(posedge clk); #2 resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_accept", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #2 req1_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a divide, counter at 20.
        send(1'b0, 32'd900, 32'd9, 5'b00111, 1'b0);
        repeat (14) @(posedge clk);
        #2 rst_n = 1'b0;
        req0_valid = 1'b1; req0_op1 = 32'd21; req0_op2 = 32'd21; req0_opcode = 5'b00000;
        req1_valid = 1'b1; req1_op1 = 32'd1;  req1_op2 = 32'd2;  req1_opcode = 5'b00000;
        #1;
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_alu_op1", alu_op1, 32'd0);
        chk("abort_alu_opcode", {27'd0, alu_opcode}, 32'd0);
        chk("abort_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        sb.delete();
        grant_log.delete();
        @(posedge clk); #2 rst_n = 1'b1;
        #1;
        chk("post_rst_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
        @(posedge clk); #2;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        chk("post_rst_grants", grant_log.size(), 32'd1);

        // Unused opcode takes basic timing.
        send(1'b1, 32'hF0F0_0000, 32'h0000_0F0F, 5'b11111, 1'b1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequences and shares the single multi-cycle ALU between two requesters: port 0 is the pipeline execute stage, port 1 is the address/auxiliary unit.
- Arbitrates round-robin and classifies each opcode as basic, multiply or divide.
- Drives registered operands and opcode into the ALU, counts the class latency, captures the answer, and returns it tagged with the requester id over a valid/ready response channel.
- Only one operation is in flight at a time.

Parameters:
- BASIC_LAT, default 2: cycles from issue to a valid ALU answer for add/logic/shift opcodes.
- MUL_LAT, default 4: the same, for multiply opcodes 5'b00010..5'b00101.
- DIV_LAT, default 34: the same, for divide opcodes 5'b00110..5'b01001.
- All three must be 1 or more.
- Counter width is $clog2(max latency + 1).

Ports:
- clk  in  1  system clock; the only clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op1  in  32  requester 0 operand 1.
- req0_op2  in  32  requester 0 operand 2.
- req0_opcode  in  5  requester 0 ALU opcode.
- req1_valid, req1_ready, req1_op1, req1_op2, req1_opcode: same as requester 0, for requester 1.
- alu_op1  out  32  operand 1 to ALU, registered.
- alu_op2  out  32  operand 2 to ALU, registered.
- alu_opcode  out  5  opcode to ALU, registered.
- alu_answer  in  32  ALU result.
- resp_valid  out  1  response available.
- resp_id  out  1  requester that owns the response.
- resp_data  out  32  captured result.
- resp_ready  in  1  consumer accepts the response.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous on rst_n low): FSM=IDLE, alu_op1/alu_op2=0, alu_opcode=0, resp_valid=0, resp_id=0, resp_data=0, busy=0, counter=0, last_grant=1 (so requester 0 wins the first tie).
- While in reset, req*_ready=0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - The grant is combinational.
  - If exactly one reqN_valid is high, grant N.
  - If both are high, grant the requester other than last_grant.
  - reqN_ready=grantN, only in IDLE.
  - A transfer occurs on valid&ready. On that edge: latch the operands and opcode into alu_*, set resp_id=N, last_grant=N, load the counter with the class latency, and go to EXEC.
  - A requester whose valid is low is never granted.
  - Ready is 0 in all other states.
- EXEC:
  - The counter decrements every cycle. alu_* hold stable.
  - On the edge where counter==1, resp_data<=alu_answer, resp_valid<=1, and the FSM goes to RESP.
  - So the answer is sampled exactly LAT cycles after the issue edge.
- RESP:
  - resp_valid, resp_id and resp_data hold until resp_ready.
  - On resp_valid&resp_ready: resp_valid<=0 and the FSM goes to IDLE.
  - A new request cannot be accepted in the same cycle.
  - Throughput is LAT+2 cycles per op when resp_ready is held high.
- Classification:
  - 5'b00010–5'b00101 use MUL_LAT.
  - 5'b00110–5'b01001 use DIV_LAT.
  - All other values use BASIC_LAT, including unused codes; no error is flagged.
- Request inputs are ignored outside IDLE, and a requester may change its operands freely while not ready.
- Reset asserted during EXEC or RESP aborts the op: the response is lost and the ALU result is ignored.
- Back-pressure: resp_ready low for any duration stalls in RESP with the data held and no new issue.
- busy equals (state != IDLE).

Test Plan:
- Single basic op: req0 op1=5, op2=7, opcode=add (00000), resp_ready=1 -> req0_ready=1 in the issue cycle. resp_valid rises 2 cycles after issue with resp_id=0 and resp_data=ALU answer (12). busy is high for exactly 3 cycles.
- Multiply and divide latency: req1 opcode=5'b00010, then 5'b00110 -> the answer is sampled 4 and 34 cycles after issue respectively, and alu_* are held constant throughout.
- Round-robin: both valid continuously with resp_ready=1 -> grants alternate 0,1,0,1. After a reset with both valid, the first grant is 0.
- Back-pressure: resp_ready=0 for 10 cycles in RESP -> resp_valid/resp_data stay stable, req*_ready stay 0, and acceptance happens on the first cycle resp_ready=1.
- Reset mid-divide: assert rst_n=0 at EXEC counter=20 -> all outputs return to reset values immediately. After release, a new req0 op completes normally with correct latency.
- Unused opcode 5'b11111 -> BASIC_LAT timing and normal response.
